// File: rtl/dcr_bank.sv
// dcr_bank: host-addressable device control register bank with a kernel
// launch handshake toward the dispatcher.
// Registers: 0 THREAD_COUNT, 1 PROGRAM_BASE, 2 DATA_BASE, 3 CTRL.
// Optional feature macro: DCR_WRITE_ERR_EN adds a sticky err_flag (CTRL bit3)
// that records writes dropped while a kernel is in flight.
module dcr_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  device_control_write_enable,
    input  logic                  device_control_read_enable,
    input  logic [ADDR_BITS-1:0]  device_control_addr,
    input  logic [DATA_WIDTH-1:0] device_control_data,
    output logic [DATA_WIDTH-1:0] device_control_read_data,
    output logic [DATA_WIDTH-1:0] thread_count,
    output logic [DATA_WIDTH-1:0] program_base,
    output logic [DATA_WIDTH-1:0] data_base,
    output logic                  start,
    input  logic                  start_ack,
    input  logic                  done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] thread_count_q;
    logic [DATA_WIDTH-1:0] program_base_q;
    logic [DATA_WIDTH-1:0] data_base_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [DATA_WIDTH-1:0] read_mux;
    logic [DATA_WIDTH-1:0] ctrl_word;
    logic                  done_flag_q;
    logic                  err_flag;

    logic sel_tc, sel_pb, sel_db, sel_ctrl;
    logic wr_ctrl, go_req, done_set, clr_done;

    // Full-width address decode so addresses 4 and above hit nothing.
    assign sel_tc   = (device_control_addr == ADDR_BITS'(0));
    assign sel_pb   = (device_control_addr == ADDR_BITS'(1));
    assign sel_db   = (device_control_addr == ADDR_BITS'(2));
    assign sel_ctrl = (device_control_addr == ADDR_BITS'(3));

    assign wr_ctrl  = device_control_write_enable && sel_ctrl;
    assign go_req   = wr_ctrl && device_control_data[0];
    assign clr_done = wr_ctrl && device_control_data[1];
    // Completion can arrive together with the ack, skipping RUN entirely.
    assign done_set = done && ((state_q == RUN) || ((state_q == LAUNCH) && start_ack));

    // Next-state logic for the launch handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go_req && (thread_count_q != '0)) state_d = LAUNCH;
            end
            LAUNCH: begin
                if (start_ack) state_d = done ? IDLE : RUN;
            end
            RUN: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Configuration registers, writable only while no kernel is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            thread_count_q <= '0;
            program_base_q <= '0;
            data_base_q    <= '0;
        end else if (device_control_write_enable && (state_q == IDLE)) begin
            if (sel_tc) thread_count_q <= device_control_data;
            if (sel_pb) program_base_q <= device_control_data;
            if (sel_db) data_base_q    <= device_control_data;
        end
    end

    // Sticky completion flag; a completion in the same cycle beats the clear.
    always_ff @(posedge clk) begin
        if (reset)         done_flag_q <= 1'b0;
        else if (done_set) done_flag_q <= 1'b1;
        else if (clr_done) done_flag_q <= 1'b0;
    end

`ifdef DCR_WRITE_ERR_EN
    logic err_flag_q;
    logic err_set, err_clr;

    assign err_set = (state_q != IDLE) && device_control_write_enable &&
                     (sel_tc || sel_pb || sel_db || (sel_ctrl && device_control_data[0]));
    assign err_clr = wr_ctrl && device_control_data[3];

    // Sticky error flag recording writes dropped while busy.
    always_ff @(posedge clk) begin
        if (reset)        err_flag_q <= 1'b0;
        else if (err_set) err_flag_q <= 1'b1;
        else if (err_clr) err_flag_q <= 1'b0;
    end

    assign err_flag = err_flag_q;
`else
    assign err_flag = 1'b0;
`endif

    // CTRL status view assembled from live state.
    always_comb begin
        ctrl_word    = '0;
        ctrl_word[1] = (state_q != IDLE);
        ctrl_word[2] = done_flag_q;
        ctrl_word[3] = err_flag;
    end

    // Read multiplexer; unimplemented addresses return zero.
    always_comb begin
        read_mux = '0;
        if (sel_tc)   read_mux = thread_count_q;
        if (sel_pb)   read_mux = program_base_q;
        if (sel_db)   read_mux = data_base_q;
        if (sel_ctrl) read_mux = ctrl_word;
    end

    // Registered read-back; holds until the next read strobe.
    always_ff @(posedge clk) begin
        if (reset)                           read_data_q <= '0;
        else if (device_control_read_enable) read_data_q <= read_mux;
    end

    assign device_control_read_data = read_data_q;
    assign thread_count             = thread_count_q;
    assign program_base             = program_base_q;
    assign data_base                = data_base_q;
    assign start                    = (state_q == LAUNCH);
    assign busy                     = (state_q != IDLE);

endmodule

// File: tb/tb_dcr_bank.sv
// Directed testbench for dcr_bank, built with a 3-bit address so that the
// unimplemented address range 4-7 can be exercised.
module tb_dcr_bank;

    localparam int DW = 8;
    localparam int AW = 3;

`ifdef DCR_WRITE_ERR_EN
    localparam logic [7:0] ERRB = 8'h08;
`else
    localparam logic [7:0] ERRB = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic [DW-1:0] tc, pb, db;
    logic          start, busy;
    logic          start_ack = 1'b0;
    logic          done = 1'b0;

    int tests = 0;
    int fails = 0;

    dcr_bank #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .device_control_write_enable (we),
        .device_control_read_enable  (re),
        .device_control_addr         (addr),
        .device_control_data         (wdata),
        .device_control_read_data    (rdata),
        .thread_count                (tc),
        .program_base                (pb),
        .data_base                   (db),
        .start                       (start),
        .start_ack                   (start_ack),
        .done                        (done),
        .busy                        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
        re = 1'b1; addr = a;
        tick();
        re = 1'b0;
        v = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        do_reset();
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start got=%b exp=0", start); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        for (int a = 0; a < 4; a++) begin
            rd(AW'(a), v);
            tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_read%0d got=%h exp=00", a, v); end
        end
    endtask

    task automatic test_launch();
        logic [DW-1:0] v;
        wr(3'd0, 8'h20);
        tests++; if (tc !== 8'h20) begin fails++; $display("FAIL wr_tc got=%h exp=20", tc); end
        wr(3'd1, 8'h10);
        tests++; if (pb !== 8'h10) begin fails++; $display("FAIL wr_pb got=%h exp=10", pb); end
        wr(3'd2, 8'h33);
        tests++; if (db !== 8'h33) begin fails++; $display("FAIL wr_db got=%h exp=33", db); end
        rd(3'd1, v);
        tests++; if (v !== 8'h10) begin fails++; $display("FAIL rd_pb got=%h exp=10", v); end
        wr(3'd3, 8'h01);
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL go_start got=%b exp=1", start); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL go_busy got=%b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (start !== 1'b1) begin fails++; $display("FAIL hold_start%0d got=%b exp=1", i, start); end
        end
        start_ack = 1'b1;
        tick();
        start_ack = 1'b0;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL ack_start got=%b exp=0", start); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ack_busy got=%b exp=1", busy); end
    endtask

    task automatic test_run_protect();
        logic [DW-1:0] v;
        wr(3'd0, 8'h55);
        tests++; if (tc !== 8'h20) begin fails++; $display("FAIL run_tc_protect got=%h exp=20", tc); end
        rd(3'd3, v);
        tests++; if (v !== (8'h02 | ERRB)) begin fails++; $display("FAIL run_ctrl got=%h exp=%h", v, 8'h02 | ERRB); end
        wr(3'd3, 8'h01);
        tests++; if (start !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL go_while_busy got=%b%b exp=01", start, busy); end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_busy got=%b exp=0", busy); end
        rd(3'd3, v);
        tests++; if (v !== (8'h04 | ERRB)) begin fails++; $display("FAIL done_ctrl got=%h exp=%h", v, 8'h04 | ERRB); end
        wr(3'd3, 8'h0A);
        rd(3'd3, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL clr_ctrl got=%h exp=00", v); end
    endtask

    task automatic test_addr_high();
        logic [DW-1:0] v;
        wr(3'd4, 8'hAA);
        wr(3'd7, 8'h01);
        tests++; if (tc !== 8'h20 || pb !== 8'h10 || db !== 8'h33) begin
            fails++; $display("FAIL hi_write got=%h/%h/%h exp=20/10/33", tc, pb, db); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hi_go got=%b exp=0", busy); end
        rd(3'd4, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL hi_read4 got=%h exp=00", v); end
        rd(3'd6, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL hi_read6 got=%h exp=00", v); end
    endtask

    task automatic test_rw_same();
        we = 1'b1; re = 1'b1; addr = 3'd0; wdata = 8'h77;
        tick();
        we = 1'b0; re = 1'b0;
        tests++; if (rdata !== 8'h20) begin fails++; $display("FAIL rw_old got=%h exp=20", rdata); end
        tests++; if (tc !== 8'h77) begin fails++; $display("FAIL rw_new got=%h exp=77", tc); end
        tick();
        tests++; if (rdata !== 8'h20) begin fails++; $display("FAIL rd_hold got=%h exp=20", rdata); end
    endtask

    task automatic test_zero_count();
        wr(3'd0, 8'h00);
        wr(3'd3, 8'h01);
        tests++; if (start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_go got=%b%b exp=00", start, busy); end
        tick();
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL zero_go_later got=%b exp=0", start); end
    endtask

    task automatic test_ack_done_same();
        logic [DW-1:0] v;
        wr(3'd0, 8'h05);
        wr(3'd3, 8'h01);
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL ad_start got=%b exp=1", start); end
        start_ack = 1'b1; done = 1'b1;
        tick();
        start_ack = 1'b0; done = 1'b0;
        tests++; if (busy !== 1'b0 || start !== 1'b0) begin fails++; $display("FAIL ad_idle got=%b%b exp=00", busy, start); end
        rd(3'd3, v);
        tests++; if (v !== 8'h04) begin fails++; $display("FAIL ad_flag got=%h exp=04", v); end
        wr(3'd3, 8'h02);
    endtask

    task automatic test_done_clr_same();
        logic [DW-1:0] v;
        wr(3'd3, 8'h01);
        start_ack = 1'b1;
        tick();
        start_ack = 1'b0;
        tests++; if (busy !== 1'b1 || start !== 1'b0) begin fails++; $display("FAIL dc_run got=%b%b exp=10", busy, start); end
        we = 1'b1; addr = 3'd3; wdata = 8'h02; done = 1'b1;
        tick();
        we = 1'b0; done = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL dc_busy got=%b exp=0", busy); end
        rd(3'd3, v);
        tests++; if (v !== 8'h04) begin fails++; $display("FAIL dc_flag got=%h exp=04", v); end
    endtask

    task automatic test_reset_mid_run();
        wr(3'd0, 8'h20);
        wr(3'd1, 8'h11);
        wr(3'd3, 8'h01);
        start_ack = 1'b1;
        tick();
        start_ack = 1'b0;
        do_reset();
        tests++; if (busy !== 1'b0 || start !== 1'b0) begin fails++; $display("FAIL rst_run got=%b%b exp=00", busy, start); end
        tests++; if (tc !== 8'h00 || pb !== 8'h00 || db !== 8'h00 || rdata !== 8'h00) begin
            fails++; $display("FAIL rst_regs got=%h/%h/%h/%h exp=00/00/00/00", tc, pb, db, rdata); end
        wr(3'd0, 8'h01);
        wr(3'd3, 8'h01);
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL relaunch_start got=%b exp=1", start); end
        start_ack = 1'b1;
        tick();
        start_ack = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL relaunch_done got=%b exp=0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_launch();
        test_run_protect();
        test_addr_high();
        test_rw_same();
        test_zero_count();
        test_ack_done_same();
        test_done_clr_same();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
